// File: rtl/core_obuf_p2s_if.sv
// Outgoing link bus for the core output buffer: GBUS_DATA-wide beats with valid/ready handshake.
interface core_obuf_p2s_if #(
    parameter int unsigned GBUS_DATA = 64
) ();
    logic [GBUS_DATA-1:0] gbus_wdata;
    logic                 gbus_wvalid;
    logic                 gbus_wready;

    modport master (output gbus_wdata, output gbus_wvalid, input gbus_wready);
    modport slave  (input gbus_wdata, input gbus_wvalid, output gbus_wready);
endinterface

// File: rtl/core_obuf_p2s.sv
// Output buffer: FIFO of wide result words serialized LSB-slice-first onto the link bus.
// Optional sticky dropped-write flag obuf_overflow enabled by `define CORE_OBUF_OVF_FLAG_EN.
module core_obuf_p2s #(
    parameter int unsigned GBUS_DATA   = 64,
    parameter int unsigned OBUF_DATA   = 256,
    parameter int unsigned OBUF_DEPTH  = 8,
    parameter int unsigned OBUF_ADDR   = $clog2(OBUF_DEPTH),
    parameter int unsigned ALERT_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 obuf_clr,
    input  logic [OBUF_DATA-1:0] obuf_wdata,
    input  logic                 obuf_wen,
    output logic                 obuf_full,
    output logic                 obuf_almost_full,
    output logic                 obuf_empty,
    output logic                 obuf_idle,
`ifdef CORE_OBUF_OVF_FLAG_EN
    output logic                 obuf_overflow,
`endif
    core_obuf_p2s_if.master      gbus
);

    localparam int unsigned R     = OBUF_DATA / GBUS_DATA;
    localparam int unsigned CNT_W = $clog2(R);
    localparam int unsigned PTR_W = OBUF_ADDR + 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [PTR_W-1:0]       count;
    logic [OBUF_DATA-1:0]   mem [OBUF_DEPTH];
    logic [OBUF_DATA-1:0]   rdata;
    logic [OBUF_DATA-1:0]   shift_reg;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   wvalid;
    logic                   wr_en;
    logic                   ren;
    logic                   hs;
    logic                   last_beat;

    // Flags decode straight from the registered pointers; MSB is the wrap bit.
    assign obuf_empty       = (wptr == rptr);
    assign obuf_full        = (wptr[OBUF_ADDR] != rptr[OBUF_ADDR]) &&
                              (wptr[OBUF_ADDR-1:0] == rptr[OBUF_ADDR-1:0]);
    assign count            = wptr - rptr;
    assign obuf_almost_full = ((PTR_W'(OBUF_DEPTH) - count) <= PTR_W'(ALERT_DEPTH));
    assign obuf_idle        = obuf_empty && (state == IDLE);

    assign hs        = wvalid & gbus.gbus_wready;
    assign last_beat = hs && (beat_cnt == CNT_W'(R - 1));
    assign wr_en     = obuf_wen & ~obuf_full & ~obuf_clr;
    assign ren       = ~obuf_clr & ~obuf_empty & ((state == IDLE) | last_beat);

    assign gbus.gbus_wdata  = shift_reg[GBUS_DATA-1:0];
    assign gbus.gbus_wvalid = wvalid;

    // Storage array with registered read port; no reset needed on data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[OBUF_ADDR-1:0]] <= obuf_wdata;
        if (ren)   rdata <= mem[rptr[OBUF_ADDR-1:0]];
    end

    // Pointers and serializer; a pop on the last beat chains straight into FETCH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            state     <= IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
            wvalid    <= 1'b0;
        end else if (obuf_clr) begin
            wptr      <= '0;
            rptr      <= '0;
            state     <= IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
            wvalid    <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_W'(1);
            if (ren)   rptr <= rptr + PTR_W'(1);
            case (state)
                IDLE: begin
                    if (ren) state <= FETCH;
                end
                FETCH: begin
                    shift_reg <= rdata;
                    beat_cnt  <= '0;
                    wvalid    <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        shift_reg <= shift_reg >> GBUS_DATA;
                        beat_cnt  <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            wvalid <= 1'b0;
                            state  <= ren ? FETCH : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CORE_OBUF_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       obuf_overflow <= 1'b0;
        else if (obuf_clr)               obuf_overflow <= 1'b0;
        else if (obuf_wen && obuf_full)  obuf_overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_core_obuf_p2s.sv
// Self-checking bench for core_obuf_p2s: queue-based transaction model, randomized data and backpressure.
module tb_core_obuf_p2s;
    localparam int unsigned GB    = 64;
    localparam int unsigned OD    = 256;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ALERT = 2;
    localparam int unsigned R     = OD / GB;
    localparam int unsigned LIMIT = 300;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          obuf_clr = 1'b0;
    logic          obuf_wen = 1'b0;
    logic [OD-1:0] obuf_wdata = '0;
    logic          obuf_full, obuf_almost_full, obuf_empty, obuf_idle;
`ifdef CORE_OBUF_OVF_FLAG_EN
    logic          obuf_overflow;
`endif

    core_obuf_p2s_if #(.GBUS_DATA(GB)) gbus ();

    core_obuf_p2s #(
        .GBUS_DATA(GB), .OBUF_DATA(OD), .OBUF_DEPTH(DEPTH), .ALERT_DEPTH(ALERT)
    ) dut (
        .clk(clk), .rstn(rstn), .obuf_clr(obuf_clr),
        .obuf_wdata(obuf_wdata), .obuf_wen(obuf_wen),
        .obuf_full(obuf_full), .obuf_almost_full(obuf_almost_full),
        .obuf_empty(obuf_empty), .obuf_idle(obuf_idle),
`ifdef CORE_OBUF_OVF_FLAG_EN
        .obuf_overflow(obuf_overflow),
`endif
        .gbus(gbus)
    );

    always #5 clk = ~clk;

    // Reference model: queued words, beats of the word in flight, one-cycle fetch slot.
    logic [OD-1:0] m_fifo[$];
    logic [GB-1:0] m_beats[$];
    bit            m_fetch;
    logic [OD-1:0] m_fetch_word;
    bit            m_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [OD-1:0] got, input logic [OD-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        return (m_fifo.size() == 0) && !m_fetch && (m_beats.size() == 0);
    endfunction

    function automatic logic [OD-1:0] rand_word();
        logic [OD-1:0] w;
        for (int k = 0; k < OD / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [OD-1:0] lane_word();
        logic [OD-1:0] w;
        for (int i = 0; i < R; i++) w[i*GB +: GB] = GB'(i + 1);
        return w;
    endfunction

    task automatic model_step(input bit clr, input bit wen, input logic [OD-1:0] wd, input bit rdy);
        int sz;
        bit valid, hs, last, pop;
        if (clr) begin
            m_fifo.delete();
            m_beats.delete();
            m_fetch = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        sz    = m_fifo.size();
        valid = m_beats.size() > 0;
        hs    = valid && rdy;
        last  = hs && (m_beats.size() == 1);
        pop   = (sz > 0) && ((!valid && !m_fetch) || last);
        if (wen && sz == DEPTH) m_ovf = 1'b1;
        if (m_fetch) begin
            for (int i = 0; i < R; i++) m_beats.push_back(m_fetch_word[i*GB +: GB]);
            m_fetch = 1'b0;
        end else if (hs) begin
            void'(m_beats.pop_front());
        end
        if (pop) begin
            m_fetch_word = m_fifo.pop_front();
            m_fetch      = 1'b1;
        end
        if (wen && sz < DEPTH) m_fifo.push_back(wd);
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = m_beats.size() > 0;
        chk("wvalid", gbus.gbus_wvalid, exp_valid);
        if (exp_valid) chk("wdata", gbus.gbus_wdata, m_beats[0]);
        chk("empty", obuf_empty, m_fifo.size() == 0);
        chk("full", obuf_full, m_fifo.size() == DEPTH);
        chk("almost_full", obuf_almost_full, (DEPTH - m_fifo.size()) <= ALERT);
        chk("idle", obuf_idle, model_idle());
`ifdef CORE_OBUF_OVF_FLAG_EN
        chk("overflow", obuf_overflow, m_ovf);
`endif
    endtask

    // Drive at a negedge, advance one clock, check at the following negedge.
    task automatic cycle(input bit clr, input bit wen, input logic [OD-1:0] wd, input bit rdy);
        obuf_clr         = clr;
        obuf_wen         = wen;
        obuf_wdata       = wd;
        gbus.gbus_wready = rdy;
        @(posedge clk);
        model_step(clr, wen, wd, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        int n = 0;
        while (!model_idle() && n < LIMIT) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_timeout", n < LIMIT, 1'b1);
    endtask

    initial begin
        int  n;
        bit  saw_full;
        gbus.gbus_wready = 1'b0;
        m_fetch = 1'b0;
        m_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wvalid", gbus.gbus_wvalid, 1'b0);
        chk("rst_wdata", gbus.gbus_wdata, '0);
        chk("rst_empty", obuf_empty, 1'b1);
        chk("rst_idle", obuf_idle, 1'b1);
        chk("rst_full", obuf_full, 1'b0);
        chk("rst_almost_full", obuf_almost_full, 1'b0);
`ifdef CORE_OBUF_OVF_FLAG_EN
        chk("rst_overflow", obuf_overflow, 1'b0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // Single word: first beat two edges after the write edge.
        cycle(1'b0, 1'b1, lane_word(), 1'b1);
        n = 0;
        while (!gbus.gbus_wvalid && n < 10) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("latency", n, 2);
        chk("first_beat", gbus.gbus_wdata, 64'd1);
        drain();
        chk("single_idle", obuf_idle, 1'b1);

        // Backpressure on beat 2.
        cycle(1'b0, 1'b1, lane_word(), 1'b1);
        n = 0;
        while (m_beats.size() != R - 1 && n < 10) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("beat2_timeout", n < 10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            chk("stall_data", gbus.gbus_wdata, 64'd2);
            chk("stall_valid", gbus.gbus_wvalid, 1'b1);
        end
        drain();

        // Fill with link stalled; the tenth word is dropped.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, rand_word(), 1'b0);
        chk("fill_full", obuf_full, 1'b1);
        chk("fill_held", m_fifo.size(), DEPTH);
`ifdef CORE_OBUF_OVF_FLAG_EN
        chk("fill_overflow", obuf_overflow, 1'b1);
`endif
        drain();

        // Streaming at line rate with concurrent writes.
        saw_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, rand_word(), 1'b1);
            saw_full |= obuf_full;
            for (int j = 0; j < R; j++) begin
                cycle(1'b0, 1'b0, '0, 1'b1);
                saw_full |= obuf_full;
            end
        end
        chk("stream_never_full", saw_full, 1'b0);
        drain();

        // Pointer wrap-around with random backpressure.
        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, rand_word(), $urandom_range(0, 1) == 1);
            drain();
        end

        // Clear during beat 3 with four words queued; concurrent write ignored.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rand_word(), 1'b0);
        n = 0;
        while (m_beats.size() != 2 && n < 10) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("beat3_timeout", n < 10, 1'b1);
        chk("clr_queued", m_fifo.size(), 4);
        cycle(1'b1, 1'b1, rand_word(), 1'b1);
        chk("clr_wvalid", gbus.gbus_wvalid, 1'b0);
        chk("clr_empty", obuf_empty, 1'b1);
        chk("clr_idle", obuf_idle, 1'b1);
        cycle(1'b0, 1'b1, lane_word(), 1'b1);
        drain();

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rand_word(),
                  $urandom_range(0, 3) != 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
